// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
// Direct-mapped instruction cache with one 32-bit word per line. It answers
// fetch requests from the instruction-fetch stage. A hit answers one cycle
// after acceptance. A miss refills the line from the memory controller over a
// level request / done-strobe handshake, then answers. A ROB flush
// (jump_wrong) cancels any answer that is still pending.
//
// Optional feature (define ICACHE_STATS_EN): adds the hit_cnt / miss_cnt
// saturating request counters.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   rdy            : global ready; when low, every register holds its value
//   jump_wrong     : ROB mispredict flush
//   icache_enable  : fetch request from IF (level)
//   pc_to_fetch    : fetch address; bits [1:0] are ignored
//   instr_fetched  : instruction word, valid while icache_success is high
//   icache_success : one-cycle answer strobe
//   mem_req        : refill request; held until mem_done is seen
//   mem_addr       : word-aligned refill address
//   mem_done       : memory controller strobe; mem_data is valid this cycle
//   mem_data       : refill word
//   hit_cnt        : accepted hits   (ICACHE_STATS_EN only)
//   miss_cnt       : accepted misses (ICACHE_STATS_EN only)
// -----------------------------------------------------------------------------
module icache_responder #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              icache_enable,
    input  logic [ADDR_W-1:0] pc_to_fetch,
    output logic [31:0]       instr_fetched,
    output logic              icache_success,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [31:0]       mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RESPOND   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    success_q, success_d;
    logic [31:0]             instr_q, instr_d;
    logic                    memReq_q, memReq_d;
    logic [ADDR_W-1:0]       memAddr_q, memAddr_d;
    logic                    cancel_q, cancel_d;
    logic                    fill;

    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES];

    logic [INDEX_BITS-1:0]   reqIdx;
    logic [TAG_W-1:0]        reqTag;
    logic [INDEX_BITS-1:0]   fillIdx;
    logic [TAG_W-1:0]        fillTag;
    logic                    hit;
    logic                    accept;
    logic                    unusedPcBits;

    assign reqIdx       = pc_to_fetch[INDEX_BITS+1:2];
    assign reqTag       = pc_to_fetch[ADDR_W-1:INDEX_BITS+2];
    // The latched refill address doubles as the line being refilled.
    assign fillIdx      = memAddr_q[INDEX_BITS+1:2];
    assign fillTag      = memAddr_q[ADDR_W-1:INDEX_BITS+2];
    assign unusedPcBits = ^pc_to_fetch[1:0];

    assign hit    = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
    // No acceptance during an answer cycle (success_q high) so answers are
    // spaced apart; a flush in the same cycle blocks acceptance.
    assign accept = (state_q == IDLE) && icache_enable && !success_q && !jump_wrong;

    // Next-state and output logic. The answer strobe defaults low so it can
    // never stay high for two consecutive cycles.
    always_comb begin
        state_d   = state_q;
        success_d = 1'b0;
        instr_d   = instr_q;
        memReq_d  = memReq_q;
        memAddr_d = memAddr_q;
        cancel_d  = cancel_q;
        fill      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        success_d = 1'b1;
                        instr_d   = data_q[reqIdx];
                    end else begin
                        memReq_d  = 1'b1;
                        memAddr_d = {pc_to_fetch[ADDR_W-1:2], 2'b00};
                        cancel_d  = 1'b0;
                        state_d   = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                // A flush only marks the answer as cancelled; the memory
                // handshake always runs to completion and the line is kept.
                if (jump_wrong) begin
                    cancel_d = 1'b1;
                end
                if (mem_done) begin
                    fill     = 1'b1;
                    memReq_d = 1'b0;
                    instr_d  = mem_data;
                    if (cancel_q || jump_wrong) begin
                        state_d = IDLE;
                    end else begin
                        success_d = 1'b1;
                        state_d   = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and valid-bit registers; rdy low freezes them all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            success_q <= 1'b0;
            instr_q   <= 32'h0;
            memReq_q  <= 1'b0;
            memAddr_q <= '0;
            cancel_q  <= 1'b0;
            valid_q   <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            success_q <= success_d;
            instr_q   <= instr_d;
            memReq_q  <= memReq_d;
            memAddr_q <= memAddr_d;
            cancel_q  <= cancel_d;
            if (fill) begin
                valid_q[fillIdx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            tag_q[fillIdx]  <= fillTag;
            data_q[fillIdx] <= mem_data;
        end
    end

    assign instr_fetched  = instr_q;
    assign icache_success = success_q;
    assign mem_req        = memReq_q;
    assign mem_addr       = memAddr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hitCnt_q, missCnt_q;

    // Saturating counters over accepted requests. A request that is later
    // flushed has still been counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCnt_q  <= 32'h0;
            missCnt_q <= 32'h0;
        end else if (rdy && accept) begin
            if (hit) begin
                if (hitCnt_q != 32'hFFFF_FFFF) hitCnt_q <= hitCnt_q + 32'd1;
            end else begin
                if (missCnt_q != 32'hFFFF_FFFF) missCnt_q <= missCnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hitCnt_q;
    assign miss_cnt = missCnt_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_responder
// Self-checking bench for icache_responder. A table of fetch vectors is
// applied in order. Every answer the bench expects is pushed to a scoreboard
// queue, and a monitor pops and compares it whenever the cache strobes
// icache_success. Hand-written sequences cover flushes, rdy stalls and
// asynchronous reset in the middle of a refill.
// -----------------------------------------------------------------------------
module tb_icache_responder;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        jump_wrong;
    logic        icache_enable;
    logic [31:0] pc_to_fetch;
    logic [31:0] instr_fetched;
    logic        icache_success;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int tests;
    int failed;

    logic [31:0] sbQ[$];
    logic        lastSuccess;

    typedef struct {
        logic [31:0] pc;
        bit          expHit;
        logic [31:0] word;
        int          memLat;
    } vector_t;

    vector_t vectors[10];

    icache_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .jump_wrong     (jump_wrong),
        .icache_enable  (icache_enable),
        .pc_to_fetch    (pc_to_fetch),
        .instr_fetched  (instr_fetched),
        .icache_success (icache_success),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_done       (mem_done),
        .mem_data       (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bound the whole run so a stuck design can never hang the bench.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Shared comparison routine; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected word,
    // and no two strobes may be adjacent.
    always @(negedge clk) begin
        if (icache_success === 1'b1) begin
            checkOutput("strobeSpacing", {31'b0, lastSuccess}, 32'h0);
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedSuccess", 32'h1, 32'h0);
            end else begin
                checkOutput("scoreboardWord", instr_fetched, sbQ.pop_front());
            end
        end
        lastSuccess = (icache_success === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies one fetch; assumes it is called just after a rising edge with
    // the cache idle. Returns just after the cache is idle again.
    task automatic applyStimulus(input logic [31:0] pc, input bit expHit,
                                 input logic [31:0] word, input int memLat);
        icache_enable = 1'b1;
        pc_to_fetch   = pc;
        sbQ.push_back(word);
        tick();
        icache_enable = 1'b0;
        if (expHit) begin
            checkOutput("hitSuccess", {31'b0, icache_success}, 32'h1);
            checkOutput("hitNoMemReq", {31'b0, mem_req}, 32'h0);
        end else begin
            checkOutput("missReq", {31'b0, mem_req}, 32'h1);
            checkOutput("missAddr", mem_addr, pc & 32'hFFFF_FFFC);
            checkOutput("missNoEarlySuccess", {31'b0, icache_success}, 32'h0);
            for (int i = 1; i < memLat; i++) begin
                tick();
                checkOutput("missReqHeld", {31'b0, mem_req}, 32'h1);
            end
            mem_done = 1'b1;
            mem_data = word;
            tick();
            mem_done = 1'b0;
            mem_data = 32'hDEAD_BEEF;
            checkOutput("refillReqDropped", {31'b0, mem_req}, 32'h0);
            checkOutput("missSuccess", {31'b0, icache_success}, 32'h1);
        end
        tick();
        checkOutput("strobeOneCycle", {31'b0, icache_success}, 32'h0);
    endtask

    initial begin
        tests         = 0;
        failed        = 0;
        lastSuccess   = 1'b0;
        rst_n         = 1'b0;
        rdy           = 1'b1;
        jump_wrong    = 1'b0;
        icache_enable = 1'b0;
        pc_to_fetch   = 32'h0;
        mem_done      = 1'b0;
        mem_data      = 32'h0;

        // Expected hit/miss pattern worked out by hand from index/tag fields.
        vectors[0] = '{32'h0000_0010, 1'b0, 32'h0013_0093, 3};
        vectors[1] = '{32'h0000_0010, 1'b1, 32'h0013_0093, 0};
        vectors[2] = '{32'h0000_0110, 1'b0, 32'h1111_0110, 2};
        vectors[3] = '{32'h0000_0010, 1'b0, 32'h0013_0093, 4};
        vectors[4] = '{32'h0000_0110, 1'b0, 32'h1111_0110, 1};
        vectors[5] = '{32'h0000_0014, 1'b0, 32'hDEAD_0014, 2};
        vectors[6] = '{32'h0000_0016, 1'b1, 32'hDEAD_0014, 0};
        vectors[7] = '{32'hFFFF_FFFC, 1'b0, 32'hCAFE_F00D, 2};
        vectors[8] = '{32'hFFFF_FFFC, 1'b1, 32'hCAFE_F00D, 0};
        vectors[9] = '{32'h0000_0110, 1'b1, 32'h1111_0110, 0};

        // Reset values.
        #12;
        checkOutput("resetSuccess", {31'b0, icache_success}, 32'h0);
        checkOutput("resetInstr", instr_fetched, 32'h0);
        checkOutput("resetMemReq", {31'b0, mem_req}, 32'h0);
        checkOutput("resetMemAddr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Cold miss, hit, conflict eviction.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i].pc, vectors[i].expHit, vectors[i].word, vectors[i].memLat);
        end
`ifdef ICACHE_STATS_EN
        checkOutput("statsHit", hit_cnt, 32'd1);
        checkOutput("statsMiss", miss_cnt, 32'd3);
`endif
        for (int i = 4; i < 10; i++) begin
            applyStimulus(vectors[i].pc, vectors[i].expHit, vectors[i].word, vectors[i].memLat);
        end

        // Flush during MISS_WAIT: refill completes silently, line is kept.
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0000_0200;
        tick();
        icache_enable = 1'b0;
        checkOutput("flushMissReq", {31'b0, mem_req}, 32'h1);
        jump_wrong = 1'b1;
        tick();
        jump_wrong = 1'b0;
        checkOutput("flushReqHeld", {31'b0, mem_req}, 32'h1);
        tick();
        mem_done = 1'b1;
        mem_data = 32'hA5A5_0200;
        tick();
        mem_done = 1'b0;
        checkOutput("flushReqDropped", {31'b0, mem_req}, 32'h0);
        checkOutput("flushNoSuccess", {31'b0, icache_success}, 32'h0);
        tick();
        checkOutput("flushNoLateSuccess", {31'b0, icache_success}, 32'h0);
        applyStimulus(32'h0000_0200, 1'b1, 32'hA5A5_0200, 0);

        // Flush coinciding with mem_done.
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0000_0300;
        tick();
        icache_enable = 1'b0;
        mem_done   = 1'b1;
        mem_data   = 32'h0300_BEEF;
        jump_wrong = 1'b1;
        tick();
        mem_done   = 1'b0;
        jump_wrong = 1'b0;
        checkOutput("flushDoneNoSuccess", {31'b0, icache_success}, 32'h0);
        checkOutput("flushDoneReqDropped", {31'b0, mem_req}, 32'h0);
        tick();
        checkOutput("flushDoneIdle", {31'b0, icache_success}, 32'h0);
        applyStimulus(32'h0000_0300, 1'b1, 32'h0300_BEEF, 0);

        // Flush in the acceptance cycle of a hit; a stray mem_done in IDLE
        // is ignored; the held request is accepted next cycle.
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0000_0300;
        jump_wrong    = 1'b1;
        mem_done      = 1'b1;
        mem_data      = 32'h1234_5678;
        tick();
        jump_wrong = 1'b0;
        mem_done   = 1'b0;
        checkOutput("flushHitSuppressed", {31'b0, icache_success}, 32'h0);
        checkOutput("flushHitNoMemReq", {31'b0, mem_req}, 32'h0);
        sbQ.push_back(32'h0300_BEEF);
        tick();
        icache_enable = 1'b0;
        checkOutput("hitAfterFlush", {31'b0, icache_success}, 32'h1);
        tick();

        // rdy low for two cycles during MISS_WAIT delays the answer by two.
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0000_0400;
        sbQ.push_back(32'h0400_0001);
        tick();
        icache_enable = 1'b0;
        rdy      = 1'b0;
        mem_done = 1'b1;
        mem_data = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stallReqHeld", {31'b0, mem_req}, 32'h1);
            checkOutput("stallAddrHeld", mem_addr, 32'h0000_0400);
            checkOutput("stallNoSuccess", {31'b0, icache_success}, 32'h0);
        end
        rdy      = 1'b1;
        mem_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stallWaitNoSuccess", {31'b0, icache_success}, 32'h0);
        end
        mem_done = 1'b1;
        mem_data = 32'h0400_0001;
        tick();
        mem_done = 1'b0;
        checkOutput("stallSuccess", {31'b0, icache_success}, 32'h1);
        tick();

        // Asynchronous reset mid-refill drops the request and clears lines.
        icache_enable = 1'b1;
        pc_to_fetch   = 32'h0000_0500;
        tick();
        icache_enable = 1'b0;
        checkOutput("resetRefillReq", {31'b0, mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetReq", {31'b0, mem_req}, 32'h0);
        checkOutput("asyncResetAddr", mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
        checkOutput("asyncResetHitCnt", hit_cnt, 32'h0);
        checkOutput("asyncResetMissCnt", miss_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        applyStimulus(32'h0000_0010, 1'b0, 32'h0013_0093, 2);

        tick();
        checkOutput("scoreboardDrained", sbQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
